oled_spi_tx: RTL and testbench

Byte-level SPI transmitter for the SSD1331 PMOD OLED. It sits directly downstream of OLED_interface. The interface sequencer hands it one command or data byte at a time, with a D/C flag. This block serializes the byte MSB-first onto MOSI/SCK with chip select framing, then signals completion so the sequencer can issue the next byte.

---
 rtl/oled_spi_tx.sv | 117 +++++++++++
 tb/tb_oled_spi_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_tx.sv
// Byte-level SPI (mode 3) transmitter for the SSD1331 OLED: serializes one
// command/data byte MSB-first with CS framing and a one-cycle done pulse.
module oled_spi_tx #(
  parameter int unsigned N            = 8,
  parameter int unsigned SCLK_DIVIDER = 1
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  input  logic         i_START,
  input  logic [N-1:0] i_DATA,
  input  logic         i_DC,
  output logic         o_READY,
  output logic         o_DONE,
  output logic         o_CS,
  output logic         o_MOSI,
  output logic         o_SCK,
  output logic         o_DC
);

  localparam int unsigned PW = $clog2(SCLK_DIVIDER + 1);
  localparam int unsigned BW = $clog2(N + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(SCLK_DIVIDER - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD} state_t;

  state_t         state_q;
  logic [PW-1:0]  phase_q;
  logic [BW-1:0]  bit_q;
  logic [N-1:0]   shift_q;
  logic [N-1:0]   shift_d;
  logic           phase_end;
  logic           ready_q, done_q, cs_q, mosi_q, sck_q, dc_q;

  assign phase_end = (phase_q == PH_LAST);
  assign shift_d   = shift_q << 1;

  // Outputs are registered alongside the state so each state's levels appear
  // in the cycles spent in that state.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b1;
      dc_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        phase_q <= phase_end ? '0 : phase_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (i_START) begin
            shift_q <= i_DATA;
            dc_q    <= i_DC;
            mosi_q  <= i_DATA[N-1];
            ready_q <= 1'b0;
            cs_q    <= 1'b0;
            sck_q   <= 1'b1;
            bit_q   <= '0;
            phase_q <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (phase_end) begin
            sck_q   <= 1'b0;
            state_q <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            sck_q   <= 1'b1;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (phase_end) begin
            if (bit_q == BIT_LAST) begin
              state_q <= HOLD;
            end else begin
              // Next bit changes together with the falling SCK edge.
              shift_q <= shift_d;
              mosi_q  <= shift_d[N-1];
              sck_q   <= 1'b0;
              bit_q   <= bit_q + 1'b1;
              state_q <= LOW;
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            cs_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_READY = ready_q;
  assign o_DONE  = done_q;
  assign o_CS    = cs_q;
  assign o_MOSI  = mosi_q;
  assign o_SCK   = sck_q;
  assign o_DC    = dc_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Scoreboard bench for oled_spi_tx: instance 0 uses SCK half-period 1,
// instance 1 uses half-period 3; a panel-side monitor captures each frame.
module tb_oled_spi_tx;

  localparam int H0 = 1;
  localparam int H1 = 3;

  logic       clk;
  logic [1:0] rst, start, dcin;
  logic [7:0] data [2];
  logic [1:0] ready, done, cs, mosi, sck, dc;

  int checks   = 0;
  int failures = 0;

  // Entries: {instance, dc, byte}
  logic [9:0] exp_q [$];

  oled_spi_tx #(.N(8), .SCLK_DIVIDER(H0)) u_dut0 (
    .i_CLK(clk), .i_RST(rst[0]), .i_START(start[0]), .i_DATA(data[0]), .i_DC(dcin[0]),
    .o_READY(ready[0]), .o_DONE(done[0]), .o_CS(cs[0]), .o_MOSI(mosi[0]),
    .o_SCK(sck[0]), .o_DC(dc[0])
  );

  oled_spi_tx #(.N(8), .SCLK_DIVIDER(H1)) u_dut1 (
    .i_CLK(clk), .i_RST(rst[1]), .i_START(start[1]), .i_DATA(data[1]), .i_DC(dcin[1]),
    .o_READY(ready[1]), .o_DONE(done[1]), .o_CS(cs[1]), .o_MOSI(mosi[1]),
    .o_SCK(sck[1]), .o_DC(dc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Panel-side monitor state, one slot per instance
  int         nb [2]     = '{0, 0};
  int         run [2]    = '{0, 0};
  int         lowcnt [2] = '{0, 0};
  logic [7:0] sh [2]     = '{8'h00, 8'h00};
  logic       prev_sck [2]  = '{1'b1, 1'b1};
  logic       prev_cs [2]   = '{1'b1, 1'b1};
  logic       prev_done [2] = '{1'b0, 1'b0};
  logic       dc0 [2]       = '{1'b0, 1'b0};
  logic       dc_ok [2]     = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int hv;
      logic [9:0] e;
      hv = (g == 0) ? H0 : H1;
      if (done[g] === 1'b1) begin
        chk("done_single_pulse", 32'(prev_done[g]), 32'd0);
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'(done[g]), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_instance", 32'(e[9]), 32'(g));
          chk("frame_byte", 32'(sh[g]), 32'(e[7:0]));
          chk("frame_bits", 32'(nb[g]), 32'd8);
          chk("frame_dc_stable", 32'(dc_ok[g]), 32'd1);
          chk("frame_dc", 32'(dc0[g]), 32'(e[8]));
          chk("ready_low_cycles", 32'(lowcnt[g]), 32'(18 * hv));
        end
      end
      if (cs[g] === 1'b0) begin
        if (prev_cs[g] === 1'b1) begin
          nb[g] = 0; sh[g] = 8'h00; run[g] = 1; dc0[g] = dc[g]; dc_ok[g] = 1'b1;
        end else begin
          if (dc[g] !== dc0[g]) dc_ok[g] = 1'b0;
          if (sck[g] !== prev_sck[g]) begin
            chk("sck_phase_len", 32'(run[g]), 32'(hv));
            run[g] = 1;
            if (sck[g] === 1'b1) begin
              sh[g] = {sh[g][6:0], mosi[g]};
              nb[g]++;
            end
          end else begin
            run[g]++;
          end
        end
      end
      if (ready[g] === 1'b1) lowcnt[g] = 0;
      else lowcnt[g]++;
      prev_sck[g]  = sck[g];
      prev_cs[g]   = cs[g];
      prev_done[g] = done[g];
    end
  end

  task automatic wait_ready(input int g);
    int n = 0;
    while (ready[g] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("ready_timeout", 32'(ready[g]), 32'd1);
  endtask

  task automatic wait_done(input int g, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done[g] !== 1'b1 && n < 500);
    if (n >= 500) chk("done_timeout", 32'(done[g]), 32'd1);
  endtask

  task automatic send(input int g, input logic [7:0] b, input logic d);
    wait_ready(g);
    exp_q.push_back({1'(g), d, b});
    start[g] = 1'b1; data[g] = b; dcin[g] = d;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  initial begin
    int c1, c2, rises;
    logic p;
    rst = 2'b11; start = 2'b11; dcin = 2'b00;
    data[0] = 8'hFF; data[1] = 8'hFF;

    // Reset for two cycles with start asserted: reset must win
    repeat (2) @(negedge clk);
    rst = 2'b00; start = 2'b00;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ready", 32'(ready[g]), 32'd1);
      chk("rst_cs",    32'(cs[g]),    32'd1);
      chk("rst_sck",   32'(sck[g]),   32'd1);
      chk("rst_mosi",  32'(mosi[g]),  32'd0);
      chk("rst_dc",    32'(dc[g]),    32'd0);
      chk("rst_done",  32'(done[g]),  32'd0);
    end

    // Command byte at H=1
    send(0, 8'hA5, 1'b0);
    wait_done(0, c1);
    chk("a5_cs_after_done", 32'(cs[0]), 32'd1);

    // Data byte at H=3
    send(1, 8'h3C, 1'b1);
    wait_done(1, c1);
    chk("3c_ready_after_done", 32'(ready[1]), 32'd1);

    // Back-to-back with start held high
    repeat (2) @(negedge clk);
    exp_q.push_back({1'b0, 1'b0, 8'h81});
    exp_q.push_back({1'b0, 1'b0, 8'h7E});
    start[0] = 1'b1; data[0] = 8'h81; dcin[0] = 1'b0;
    @(negedge clk);
    chk("b2b_accept1", 32'(ready[0]), 32'd0);
    data[0] = 8'h7E;
    wait_done(0, c1);
    chk("b2b_cs_gap_high", 32'(cs[0]), 32'd1);
    @(negedge clk);
    start[0] = 1'b0;
    chk("b2b_cs_gap_len", 32'(cs[0]), 32'd0);
    chk("b2b_accept2", 32'(ready[0]), 32'd0);
    wait_done(0, c2);
    chk("b2b_done_spacing", 32'(c2 + 1), 32'd19);

    // Busy protection: input noise mid-frame must not affect the frame
    repeat (2) @(negedge clk);
    send(0, 8'hF0, 1'b0);
    repeat (3) @(negedge clk);
    data[0] = 8'h0F; dcin[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start[0] = ~start[0];
      @(negedge clk);
    end
    start[0] = 1'b0;
    wait_done(0, c1);
    repeat (5) @(negedge clk);
    chk("busy_no_extra_cs", 32'(cs[0]), 32'd1);
    chk("busy_no_extra_ready", 32'(ready[0]), 32'd1);
    dcin[0] = 1'b0;

    // Reset after the third SCK rising edge of 0xAA
    send(0, 8'hAA, 1'b0);
    rises = 0; c1 = 0; p = sck[0];
    while (rises < 3 && c1 < 100) begin
      @(negedge clk);
      c1++;
      if (sck[0] === 1'b1 && p === 1'b0) rises++;
      p = sck[0];
    end
    chk("abort_rises_seen", 32'(rises), 32'd3);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("abort_cs",    32'(cs[0]),    32'd1);
    chk("abort_sck",   32'(sck[0]),   32'd1);
    chk("abort_ready", 32'(ready[0]), 32'd1);
    chk("abort_done",  32'(done[0]),  32'd0);
    void'(exp_q.pop_back());
    rst[0] = 1'b0;
    @(negedge clk);
    chk("abort_no_late_done", 32'(done[0]), 32'd0);
    send(0, 8'h55, 1'b0);
    wait_done(0, c1);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
